// File: rtl/prio_event_encoder.sv
// prio_event_encoder
// Registered priority encoder for sparse event lines. Every req_i bit latches
// into a sticky pending register; the winning pending index is moved into a
// valid/ready output slot, one index per accepted handshake.
// Optional build macro: PRIO_EVENT_RR_EN selects round-robin arbitration
// (rr_ptr register) instead of fixed MSB-first priority.
module prio_event_encoder #(
   parameter int WIDTH = 16,
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] req_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] pend_o,
   output logic             ovf_o,
   input  logic             ovf_clr_i
);

   logic [WIDTH-1:0] pend_q, pend_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             valid_q, valid_d;
   logic             ovf_q, ovf_d;

   logic [IDX_W-1:0] win_idx;
   logic [WIDTH-1:0] win_oh;
   logic [WIDTH-1:0] load_mask;
   logic             load;

`ifdef PRIO_EVENT_RR_EN
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0] hi_any, hi_le;
   logic             found_le;

   // Round-robin winner: highest pending index at or below rr_ptr, else wrap to highest overall
   always_comb begin
      hi_any   = '0;
      hi_le    = '0;
      found_le = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if (pend_q[i]) begin
            hi_any = IDX_W'(i);
            if (IDX_W'(i) <= rr_ptr_q) begin
               hi_le    = IDX_W'(i);
               found_le = 1'b1;
            end
         end
      end
      win_idx = found_le ? hi_le : hi_any;
   end

   // Pointer moves just below the served index so lower sources get the next turn
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (load) begin
         rr_ptr_d = (win_idx == '0) ? IDX_W'(WIDTH - 1) : win_idx - IDX_W'(1);
      end
   end

   // Round-robin pointer register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q <= IDX_W'(WIDTH - 1);
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end
`else
   // Fixed winner: highest set index of the registered pending vector
   always_comb begin
      win_idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (pend_q[i]) begin
            win_idx = IDX_W'(i);
         end
      end
   end
`endif

   // One-hot form of the winner, used to clear the served pending bit
   always_comb begin
      win_oh = '0;
      for (int i = 0; i < WIDTH; i++) begin
         win_oh[i] = (IDX_W'(i) == win_idx);
      end
   end

   // Slot loads whenever it is empty or being emptied and something is pending
   always_comb begin
      load      = (!valid_q || ready_i) && (pend_q != '0);
      load_mask = load ? win_oh : '0;
   end

   // Next-state: pending set-wins-over-clear, slot load/drain, sticky coalesce flag
   always_comb begin
      pend_d  = (pend_q & ~load_mask) | req_i;
      idx_d   = idx_q;
      valid_d = valid_q;
      if (load) begin
         idx_d   = win_idx;
         valid_d = 1'b1;
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end
      // A request hitting a bit that stays pending is a lost (coalesced) event
      if ((req_i & pend_q & ~load_mask) != '0) begin
         ovf_d = 1'b1;
      end else if (ovf_clr_i) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q  <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         pend_q  <= pend_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
      end
   end

   assign pend_o  = pend_q;
   assign idx_o   = idx_q;
   assign valid_o = valid_q;
   assign ovf_o   = ovf_q;

endmodule
